// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the column-mixing datapath.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]      aes_col_t;

  typedef enum logic {
    MIX_FWD = 1'b0,
    MIX_INV = 1'b1
  } mix_op_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // All MixColumns coefficients fit in 4 bits, so a 4-step shift-and-add suffices.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns on a single 4-byte column.
module aes_mix_single_column
  import aes_pkg::*;
(
  input  mix_op_e  op_i,
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  aes_col_t fwd;
  aes_col_t inv;

  // Both matrices are circulant: row r uses bytes r, r+1, r+2, r+3 (mod 4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam logic [1:0] R0 = 2'(r);
    localparam logic [1:0] R1 = 2'((r + 1) % 4);
    localparam logic [1:0] R2 = 2'((r + 2) % 4);
    localparam logic [1:0] R3 = 2'((r + 3) % 4);

    assign fwd[r] = gf_mul(col_i[R0], 4'h2) ^ gf_mul(col_i[R1], 4'h3)
                  ^ col_i[R2] ^ col_i[R3];
    assign inv[r] = gf_mul(col_i[R0], 4'he) ^ gf_mul(col_i[R1], 4'hb)
                  ^ gf_mul(col_i[R2], 4'hd) ^ gf_mul(col_i[R3], 4'h9);
  end

  assign col_o = (op_i == MIX_FWD) ? fwd : inv;

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequenced MixColumns: mixes NUM_LANES columns per cycle in place and holds
// the result behind a valid/ready output.
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  aes_state_t data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output aes_state_t data_o,
  output logic       busy_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and DONE's ready follows out_ready_i.

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
    $error("aes_mix_columns_seq: NUM_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  localparam logic [2:0] STEP = 3'(NUM_LANES);

  fsm_e       state_q, state_d;
  aes_state_t data_q, data_d;
  mix_op_e    op_q, op_d;
  logic [1:0] col_q, col_d;
  logic       accept;
  logic       last_grp;

  aes_col_t   lane_out [4];
  aes_state_t mixed;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    if (l < NUM_LANES) begin : g_mix
      aes_mix_single_column u_mix (
        .op_i  (op_q),
        .col_i (data_q[col_q + 2'(l)]),
        .col_o (lane_out[l])
      );
    end else begin : g_unused
      assign lane_out[l] = '0;
    end
  end

  // Column c is covered this cycle when its offset from col_q is below NUM_LANES.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [1:0] off;
    assign off      = 2'(c) - col_q;
    assign mixed[c] = ({1'b0, off} < STEP) ? lane_out[off] : data_q[c];
  end

  assign last_grp = ({1'b0, col_q} + STEP) == 3'd4;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    col_d       = col_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        accept     = in_valid_i;
      end
      S_BUSY: begin
        busy_o = 1'b1;
        data_d = mixed;
        col_d  = col_q + STEP[1:0];
        if (last_grp) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          accept  = in_valid_i;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      data_d  = data_i;
      op_d    = mix_op_e'(op_i);
      col_d   = 2'd0;
      state_d = S_BUSY;
    end

    if (rst) in_ready_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= MIX_FWD;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      col_q   <= col_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: NUM_LANES 1, 2 and 4 instances, vector table,
// scoreboard on the single-lane instance and hand-written corner sequences.
module tb_aes_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid_a  [3];
  logic       in_ready_a  [3];
  logic       out_valid_a [3];
  logic       out_ready_a [3];
  logic       busy_a      [3];
  logic       op_a        [3];
  aes_state_t data_in_a   [3];
  aes_state_t data_out_a  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mix_columns_seq #(.NUM_LANES(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk         (clk),
      .rst         (rst),
      .op_i        (op_a[g]),
      .in_valid_i  (in_valid_a[g]),
      .in_ready_o  (in_ready_a[g]),
      .data_i      (data_in_a[g]),
      .out_valid_o (out_valid_a[g]),
      .out_ready_i (out_ready_a[g]),
      .data_o      (data_out_a[g]),
      .busy_o      (busy_a[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: FIPS-197 xtime formulation, inverse via pre-conditioning.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_col_t fwd_col(input aes_col_t a);
    aes_col_t   r;
    logic [7:0] t;
    t = a[0] ^ a[1] ^ a[2] ^ a[3];
    for (int i = 0; i < 4; i++) r[i] = a[i] ^ t ^ xt(a[i] ^ a[(i + 1) % 4]);
    return r;
  endfunction

  function automatic aes_col_t inv_col(input aes_col_t a);
    logic [7:0] u, v;
    aes_col_t   b;
    u = xt(xt(a[0] ^ a[2]));
    v = xt(xt(a[1] ^ a[3]));
    b[0] = a[0] ^ u; b[1] = a[1] ^ v; b[2] = a[2] ^ u; b[3] = a[3] ^ v;
    return fwd_col(b);
  endfunction

  function automatic aes_state_t model(input aes_state_t d, input logic op);
    aes_state_t r;
    for (int c = 0; c < 4; c++) r[c] = op ? inv_col(d[c]) : fwd_col(d[c]);
    return r;
  endfunction

  function automatic aes_col_t mk(input logic [7:0] b0, b1, b2, b3);
    aes_col_t c;
    c[0] = b0; c[1] = b1; c[2] = b2; c[3] = b3;
    return c;
  endfunction

  function automatic aes_state_t st(input aes_col_t c0, c1, c2, c3);
    aes_state_t s;
    s[0] = c0; s[1] = c1; s[2] = c2; s[3] = c3;
    return s;
  endfunction

  function automatic aes_state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard on the single-lane instance: push at accept, pop at output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid_a[0] && out_ready_a[0]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h with no transaction pending", data_out_a[0]);
        end else begin
          check("scoreboard", data_out_a[0], exp_q.pop_front());
        end
      end
      if (in_valid_a[0] && in_ready_a[0]) exp_q.push_back(model(data_in_a[0], op_a[0]));
    end
  end

  // Drive one transaction on instance u and wait for its result.
  task automatic send(input int u, input aes_state_t d, input logic op, input int exp_lat,
                      input bit scramble, output aes_state_t res);
    int n;
    @(posedge clk); #1;
    in_valid_a[u] = 1'b1; data_in_a[u] = d; op_a[u] = op; out_ready_a[u] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_a[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 128'(in_ready_a[u]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[u] = 1'b0;
    n = 0;
    while (n < 40) begin
      if (scramble) begin
        data_in_a[u] = rand_state();
        op_a[u]      = ~op_a[u];
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid_a[u]) break;
    end
    check("latency", 128'(n), 128'(exp_lat));
    res = data_out_a[u];
    @(posedge clk); #1;
  endtask

  typedef struct {
    string      name;
    aes_state_t din;
    logic       op;
    aes_state_t exp;
  } vec_t;

  vec_t       vecs[4];
  aes_state_t res, res2, held, a_st, b_st, d;
  aes_col_t   ones;
  int         n;

  initial begin
    ones = mk(8'h01, 8'h01, 8'h01, 8'h01);
    vecs[0] = '{"fwd_col0", st(mk(8'hdb, 8'h13, 8'h53, 8'h45), ones, ones, ones), 1'b0,
                st(mk(8'h8e, 8'h4d, 8'ha1, 8'hbc), ones, ones, ones)};
    vecs[1] = '{"inv_col0", st(mk(8'h8e, 8'h4d, 8'ha1, 8'hbc), ones, ones, ones), 1'b1,
                st(mk(8'hdb, 8'h13, 8'h53, 8'h45), ones, ones, ones)};
    vecs[2] = '{"fwd_full", st(mk(8'hf2, 8'h0a, 8'h22, 8'h5c), mk(8'hd4, 8'hd4, 8'hd4, 8'hd5),
                               mk(8'hc6, 8'hc6, 8'hc6, 8'hc6), mk(8'h2d, 8'h26, 8'h31, 8'h4c)), 1'b0,
                st(mk(8'h9f, 8'hdc, 8'h58, 8'h9d), mk(8'hd5, 8'hd5, 8'hd7, 8'hd6),
                   mk(8'hc6, 8'hc6, 8'hc6, 8'hc6), mk(8'h4d, 8'h7e, 8'hbd, 8'hf8))};
    vecs[3] = '{"inv_full", vecs[2].exp, 1'b1, vecs[2].din};

    for (int u = 0; u < 3; u++) begin
      in_valid_a[u] = 1'b0; out_ready_a[u] = 1'b0; op_a[u] = 1'b0; data_in_a[u] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_out_valid", 128'(out_valid_a[u]), 128'd0);
      check("rst_busy", 128'(busy_a[u]), 128'd0);
      check("rst_data_o", data_out_a[u], 128'd0);
      check("rst_in_ready", 128'(in_ready_a[u]), 128'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) check("post_rst_in_ready", 128'(in_ready_a[u]), 128'd1);

    // Vector table on the single-lane instance
    for (int i = 0; i < 4; i++) begin
      send(0, vecs[i].din, vecs[i].op, 4, 1'b0, res);
      check(vecs[i].name, res, vecs[i].exp);
    end

    // Two- and four-lane instances
    send(1, vecs[2].din, 1'b0, 2, 1'b0, res);
    check("lanes2_fwd", res, vecs[2].exp);
    send(2, vecs[2].din, 1'b0, 1, 1'b0, res);
    check("lanes4_fwd", res, vecs[2].exp);
    send(1, vecs[3].din, 1'b1, 2, 1'b0, res);
    check("lanes2_inv", res, vecs[3].exp);
    send(2, vecs[1].din, 1'b1, 1, 1'b0, res);
    check("lanes4_inv", res, vecs[1].exp);

    // Regression round trips
    for (int i = 0; i < 27; i++) begin
      d = rand_state();
      send(0, d, 1'b0, 4, 1'b0, res);
      send(0, res, 1'b1, 4, 1'b0, res2);
      check("round_trip", res2, d);
    end

    // Inputs toggled every cycle while busy
    d = rand_state();
    send(0, d, 1'b1, 4, 1'b1, res);
    check("scramble", res, model(d, 1'b1));

    // Backpressure then same-edge accept out of DONE
    a_st = rand_state();
    b_st = rand_state();
    @(posedge clk); #1;
    in_valid_a[0] = 1'b1; data_in_a[0] = a_st; op_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk); #1;
    data_in_a[0] = b_st; op_a[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid_a[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    held = data_out_a[0];
    check("bp_result", held, model(a_st, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", data_out_a[0], held);
      check("bp_valid_held", 128'(out_valid_a[0]), 128'd1);
      check("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    @(posedge clk); #1;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    check("bp_passthru_ready", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid_a[0]) break;
    end
    check("bp_next_latency", 128'(n), 128'd4);
    check("bp_next_result", data_out_a[0], model(b_st, 1'b1));
    @(posedge clk); #1;

    // Reset pulse after two busy cycles
    @(posedge clk); #1;
    in_valid_a[0] = 1'b1; data_in_a[0] = rand_state(); op_a[0] = 1'b0;
    @(negedge clk);
    check("rstmid_accept", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid_in_ready_low", 128'(in_ready_a[0]), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_in_ready", 128'(in_ready_a[0]), 128'd1);
    check("rstmid_busy", 128'(busy_a[0]), 128'd0);
    check("rstmid_data_o", data_out_a[0], 128'd0);
    for (int i = 0; i < 6; i++) begin
      check("rstmid_no_valid", 128'(out_valid_a[0]), 128'd0);
      @(negedge clk);
    end
    send(0, vecs[0].din, 1'b0, 4, 1'b0, res);
    check("rstmid_next", res, vecs[0].exp);

    repeat (3) @(posedge clk);
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
